// File: rtl/trace_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_chk_pkg : shared types for the processor trace self-checker    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trace_chk_pkg;

    localparam int TRACE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [TRACE_W-1:0] addr;
        logic [TRACE_W-1:0] data;
        logic               dc;
    } exp_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_exp_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_exp_mem : expected-trace register file, 1 sync wr / 1 comb rd  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_exp_mem
    import trace_chk_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type ENTRY_T = exp_entry_t,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  ENTRY_T        wr_entry,
    input  logic [IW-1:0] rd_idx,
    output ENTRY_T        rd_entry
);

    // Contents deliberately survive reset so a program can be re-checked without reloading.
    ENTRY_T r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/proc_trace_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_trace_checker : compares committed trace beats to a preloaded   |
// | expected table. Optional TRACE_CHECK_TIMEOUT_EN adds a stall timeout.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module proc_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int  W     = 32,
    parameter int  DEPTH = 16,
`ifdef TRACE_CHECK_TIMEOUT_EN
    parameter int  TMO   = 1024,
`endif
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_val,
    input  logic [IW-1:0] ld_idx,
    input  logic [W-1:0]  ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic          ld_dc,
    input  logic          start,
    input  logic [IW:0]   num,
    input  logic          trace_val,
    input  logic [W-1:0]  trace_addr,
    input  logic [W-1:0]  trace_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [IW:0]   mis_cnt,
    output logic [IW-1:0] fail_idx,
`ifdef TRACE_CHECK_TIMEOUT_EN
    output logic          timeout,
`endif
    output logic          overrun
);

    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic         dc;
    } entry_t;

    localparam logic [IW:0] C_DEPTH = (IW+1)'(DEPTH);

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [IW:0]   r_n;

    entry_t        w_wr_entry;
    entry_t        w_rd_entry;
    logic          w_wr_en;
    logic          w_match;
    logic          w_last;
    logic [IW:0]   w_num_eff;

    assign w_wr_en    = ld_val && (r_state == IDLE);
    assign w_wr_entry = '{addr: ld_addr, data: ld_data, dc: ld_dc};

    trace_exp_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_mem (
        .clk      (clk),
        .wr_en    (w_wr_en),
        .wr_idx   (ld_idx),
        .wr_entry (w_wr_entry),
        .rd_idx   (r_idx),
        .rd_entry (w_rd_entry)
    );

    // An unknown compare result falls into the mismatch branch below.
    assign w_match   = (trace_addr == w_rd_entry.addr) &&
                       (w_rd_entry.dc || (trace_data == w_rd_entry.data));
    assign w_last    = ({1'b0, r_idx} == (r_n - 1'b1));
    assign w_num_eff = (num == '0)      ? (IW+1)'(1) :
                       (num > C_DEPTH)  ? C_DEPTH    : num;

`ifdef TRACE_CHECK_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          w_tmo_hit;
    assign w_tmo_hit = (r_tmo_cnt == TW'(TMO - 1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_n       <= (IW+1)'(1);
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mis_cnt   <= '0;
            fail_idx  <= '0;
            overrun   <= 1'b0;
`ifdef TRACE_CHECK_TIMEOUT_EN
            r_tmo_cnt <= '0;
            timeout   <= 1'b0;
`endif
        end else if (start && (r_state != RUN)) begin
            r_state   <= RUN;
            r_idx     <= '0;
            r_n       <= w_num_eff;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            mis_cnt   <= '0;
            fail_idx  <= '0;
            overrun   <= 1'b0;
`ifdef TRACE_CHECK_TIMEOUT_EN
            r_tmo_cnt <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            case (r_state)
                RUN: begin
                    if (trace_val) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                        if (w_match) begin
                            if (w_last) begin
                                pass <= (mis_cnt == '0);
                            end
                        end else begin
                            if (mis_cnt != C_DEPTH) begin
                                mis_cnt <= mis_cnt + 1'b1;
                            end
                            if (mis_cnt == '0) begin
                                fail_idx <= r_idx;
                            end
                        end
`ifdef TRACE_CHECK_TIMEOUT_EN
                        r_tmo_cnt <= '0;
                    end else if (w_tmo_hit) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (trace_val) begin
                        overrun <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_trace_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_proc_trace_checker : directed + randomized bench against a model  |
// | of the expected-trace rules. Rev 1.0                                 |
// +----------------------------------------------------------------------+
module tb_proc_trace_checker;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_val = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    logic [W-1:0]  ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic          ld_dc = 1'b0;
    logic          start = 1'b0;
    logic [IW:0]   num = '0;
    logic          trace_val = 1'b0;
    logic [W-1:0]  trace_addr = '0;
    logic [W-1:0]  trace_data = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [IW:0]   mis_cnt;
    logic [IW-1:0] fail_idx;
    logic          overrun;
`ifdef TRACE_CHECK_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    proc_trace_checker #(
        .W     (W),
`ifdef TRACE_CHECK_TIMEOUT_EN
        .TMO   (8),
`endif
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_val     (ld_val),
        .ld_idx     (ld_idx),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_dc      (ld_dc),
        .start      (start),
        .num        (num),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .mis_cnt    (mis_cnt),
        .fail_idx   (fail_idx),
`ifdef TRACE_CHECK_TIMEOUT_EN
        .timeout    (timeout),
`endif
        .overrun    (overrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: expected table plus the list of beats seen since the last start.
    logic [W-1:0] m_addr [DEPTH];
    logic [W-1:0] m_data [DEPTH];
    logic         m_dc   [DEPTH];
    logic [W-1:0] q_addr [$];
    logic [W-1:0] q_data [$];
    int           m_n      = 1;
    bit           m_active = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit beat_bad(input int i);
        return (q_addr[i] !== m_addr[i]) || (!m_dc[i] && (q_data[i] !== m_data[i]));
    endfunction

    task automatic check_all(input string tag);
        int k    = q_addr.size();
        int upto = (k < m_n) ? k : m_n;
        int mis  = 0;
        int fi   = 0;
        bit e_busy, e_done, e_ovr, e_pass;
        for (int i = 0; i < upto; i++) begin
            if (beat_bad(i)) begin
                if (mis == 0) fi = i;
                mis++;
            end
        end
        if (mis > DEPTH) mis = DEPTH;
        e_busy = m_active && (k < m_n);
        e_done = m_active && (k >= m_n);
        e_ovr  = m_active && (k > m_n);
        e_pass = e_done && (mis == 0) && !e_ovr;
        check({tag, ".busy"},    busy,    e_busy);
        check({tag, ".done"},    done,    e_done);
        check({tag, ".pass"},    pass,    e_pass);
        check({tag, ".mis_cnt"}, mis_cnt, mis);
        check({tag, ".overrun"}, overrun, e_ovr);
        if (mis != 0 || !m_active) check({tag, ".fail_idx"}, fail_idx, fi);
`ifdef TRACE_CHECK_TIMEOUT_EN
        check({tag, ".timeout"}, timeout, 0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_start(input int n_req);
        if (!(m_active && (q_addr.size() < m_n))) begin
            q_addr.delete();
            q_data.delete();
            m_n      = (n_req == 0) ? 1 : ((n_req > DEPTH) ? DEPTH : n_req);
            m_active = 1'b1;
        end
    endtask

    task automatic model_load(input int idx, input logic [W-1:0] a, input logic [W-1:0] d, input logic dc);
        if (!m_active) begin
            m_addr[idx] = a;
            m_data[idx] = d;
            m_dc[idx]   = dc;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        m_active = 1'b0;
        q_addr.delete();
        q_data.delete();
        check_all(tag);
        tick();
        rst = 1'b1;
    endtask

    task automatic load(input int idx, input logic [W-1:0] a, input logic [W-1:0] d, input logic dc);
        ld_val  = 1'b1;
        ld_idx  = IW'(idx);
        ld_addr = a;
        ld_data = d;
        ld_dc   = dc;
        tick();
        ld_val  = 1'b0;
        model_load(idx, a, d, dc);
    endtask

    task automatic start_run(input string tag, input int n_req);
        start = 1'b1;
        num   = (IW+1)'(n_req);
        tick();
        start = 1'b0;
        model_start(n_req);
        check_all(tag);
    endtask

    task automatic beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] d);
        trace_val  = 1'b1;
        trace_addr = a;
        trace_data = d;
        tick();
        trace_val  = 1'b0;
        if (m_active) begin
            q_addr.push_back(a);
            q_data.push_back(d);
        end
        check_all(tag);
    endtask

    task automatic rand_beat(input string tag, input int i, input bit err);
        int           e = i % DEPTH;
        logic [W-1:0] a = m_addr[e];
        logic [W-1:0] d = m_dc[e] ? W'($urandom) : m_data[e];
        if (err) begin
            if ($urandom_range(0, 1) == 0) a = a ^ (32'd1 << $urandom_range(0, 31));
            else                           d = d ^ (32'd1 << $urandom_range(0, 31));
        end
        beat(tag, a, d);
    endtask

    initial begin
        #1;
        check_all("reset0");
        tick();
        rst = 1'b1;

        // bne program, all beats matching
        load(0, 32'h000, 32'h5, 1'b0);
        load(1, 32'h004, 32'h6, 1'b0);
        load(2, 32'h008, 32'h0, 1'b1);
        start_run("bne.start", 3);
        beat("bne.b0", 32'h000, 32'h5);
        beat("bne.b1", 32'h004, 32'h6);
        beat("bne.b2", 32'h008, 32'h1234);
        check("bne.pass_direct", pass, 1);

        // wrong data on entry 1, don't-care on entry 2
        start_run("bad.start", 3);
        beat("bad.b0", 32'h000, 32'h5);
        beat("bad.b1", 32'h004, 32'h7);
        beat("bad.b2", 32'h008, 32'hdeadbeef);
        check("bad.mis_direct", mis_cnt, 1);
        check("bad.fidx_direct", fail_idx, 1);

        // gaps between beats, then an over-run beat
        start_run("gap.start", 3);
        beat("gap.b0", 32'h000, 32'h5);
        idle(5);
        check_all("gap.idle0");
        beat("gap.b1", 32'h004, 32'h6);
        idle(5);
        beat("gap.b2", 32'h008, 32'h0);
        idle(2);
        beat("gap.over", 32'h00c, 32'h0);
        check("gap.ovr_direct", overrun, 1);

        // start while running is ignored
        start_run("rs.start", 3);
        beat("rs.b0", 32'h000, 32'h0);
        start_run("rs.restart_ignored", 3);
        beat("rs.b1", 32'h004, 32'h6);
        beat("rs.b2", 32'h008, 32'h0);

        // num = 0 behaves as one entry
        start_run("n0.start", 0);
        beat("n0.b0", 32'h000, 32'h5);

        // reset mid-run, then rerun without reloading
        start_run("mid.start", 3);
        beat("mid.b0", 32'h000, 32'h5);
        do_reset("mid.reset");
        start_run("mid.rerun", 3);
        beat("mid.b0r", 32'h000, 32'h5);
        beat("mid.b1r", 32'h004, 32'h6);
        beat("mid.b2r", 32'h008, 32'h0);

        // write and start in the same IDLE cycle
        do_reset("ls.reset");
        ld_val  = 1'b1;
        ld_idx  = '0;
        ld_addr = 32'h100;
        ld_data = 32'h55;
        ld_dc   = 1'b0;
        start   = 1'b1;
        num     = 5'd1;
        tick();
        ld_val = 1'b0;
        start  = 1'b0;
        model_load(0, 32'h100, 32'h55, 1'b0);
        model_start(1);
        check_all("ls.start");
        beat("ls.b0", 32'h100, 32'h55);

        // full depth, all wrong addresses; load during RUN must not stick
        do_reset("full.reset");
        for (int i = 0; i < DEPTH; i++) load(i, W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
        start_run("full.start", DEPTH);
        load(0, ~m_addr[0], 32'h0, 1'b1);
        for (int i = 0; i < DEPTH; i++) beat("full.bad", m_addr[i] ^ 32'h1, m_data[i]);
        check("full.mis_direct", mis_cnt, DEPTH);
        check("full.fidx_direct", fail_idx, 0);
        start_run("full.rerun", DEPTH);
        for (int i = 0; i < DEPTH; i++) rand_beat("full.good", i, 1'b0);

        // randomized programs, each followed by a restart from DONE
        for (int r = 0; r < 8; r++) begin
            do_reset("rnd.reset");
            for (int i = 0; i < DEPTH; i++) load(i, W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
            for (int p = 0; p < 2; p++) begin
                start_run("rnd.start", $urandom_range(0, DEPTH));
                for (int k = 0; k < m_n; k++) begin
                    rand_beat("rnd.beat", k, ($urandom_range(0, 4) == 0));
                    idle($urandom_range(0, 3));
                end
                if ($urandom_range(0, 1) == 1) rand_beat("rnd.over", 0, 1'b0);
            end
        end

`ifdef TRACE_CHECK_TIMEOUT_EN
        do_reset("tmo.reset");
        start_run("tmo.start", 3);
        idle(7);
        check("tmo.busy_before", busy, 1);
        idle(1);
        check("tmo.done", done, 1);
        check("tmo.timeout", timeout, 1);
        check("tmo.pass", pass, 0);
        check("tmo.busy", busy, 0);
        do_reset("tmo.clear");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
